// File: rtl/tty_screen_writer.sv
// Terminal text writer: turns received bytes into char-RAM writes, tracks the cursor,
// handles CR/LF/BS and line wrap, and scrolls by rotating the physical top row.
module tty_screen_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 12
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rbyte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ROW_W-1:0]  top_row,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(COLS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [7:0]        SPACE     = 8'h20;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR
    } state_t;

    state_t              r_state;
    logic [2:0]          r_sync;
    logic [7:0]          r_pend;
    logic                r_pend_v;
    logic [7:0]          r_cmd;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ROW_W-1:0]    r_phys_row;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ROW_W-1:0]    r_top_row;
    logic [ROW_W-1:0]    r_cur_row;
    logic [COL_W-1:0]    r_cur_col;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                r_busy;
    logic                r_overflow;

    logic                w_edge;
    logic                w_take;
    logic                w_printable;
    logic                w_newline;
    logic                w_scroll;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [ADDR_W-1:0]   w_next_base;
    logic [ROW_W-1:0]    w_next_phys;

    assign w_edge      = r_sync[1] & ~r_sync[2];
    assign w_take      = (r_state == ST_IDLE) && r_pend_v;
    assign w_printable = (r_cmd >= 8'h20) && (r_cmd <= 8'h7E);
    assign w_newline   = (w_printable && (r_cur_col == LAST_COL)) || (r_cmd == 8'h0A);
    assign w_scroll    = w_newline && (r_cur_row == LAST_ROW);
    assign w_cur_addr  = r_row_base + ADDR_W'(r_cur_col);
    // Both a plain newline and a scroll advance the cursor's physical row by one.
    assign w_next_base = (r_row_base == LAST_BASE) ? '0 : r_row_base + ROW_STEP;
    assign w_next_phys = (r_phys_row == LAST_ROW) ? '0 : r_phys_row + 1'b1;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            r_sync     <= '0;
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], rbyte_ready};
            if (w_take)
                r_pend_v <= 1'b0;
            if (w_edge) begin
                if (r_pend_v)
                    r_overflow <= 1'b1;
                else begin
                    r_pend   <= rx_byte;
                    r_pend_v <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_phys_row <= '0;
            r_row_base <= '0;
            r_top_row  <= '0;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_wr_en   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_wr_addr <= r_cnt;
                    r_wr_data <= SPACE;
                    if (r_cnt == LAST_ADDR) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                end
                ST_IDLE: begin
                    if (r_pend_v) begin
                        r_cmd   <= r_pend;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    if (w_printable) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_cur_addr;
                        r_wr_data <= r_cmd;
                        r_cur_col <= (r_cur_col == LAST_COL) ? '0 : r_cur_col + 1'b1;
                    end else if (r_cmd == 8'h0D) begin
                        r_cur_col <= '0;
                    end else if ((r_cmd == 8'h08) && (r_cur_col != '0)) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_cur_addr - 1'b1;
                        r_wr_data <= SPACE;
                        r_cur_col <= r_cur_col - 1'b1;
                    end
                    if (w_newline) begin
                        r_phys_row <= w_next_phys;
                        r_row_base <= w_next_base;
                        if (w_scroll) begin
                            r_top_row <= (r_top_row == LAST_ROW) ? '0 : r_top_row + 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_CLEAR;
                        end else
                            r_cur_row <= r_cur_row + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // r_row_base already points at the recycled old top row.
                    r_wr_en   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_wr_addr <= r_row_base + r_cnt;
                    r_wr_data <= SPACE;
                    if (r_cnt == CLR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign top_row  = r_top_row;
    assign cur_row  = r_cur_row;
    assign cur_col  = r_cur_col;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_tty_screen_writer.sv
// Directed bench for tty_screen_writer: init clear, text/control vectors, wrap, scroll, overflow.
module tb_tty_screen_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk100 = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rbyte_ready = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  top_row;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;
    logic        overflow;

    tty_screen_writer dut (
        .clk100      (clk100),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .rbyte_ready (rbyte_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .top_row     (top_row),
        .cur_row     (cur_row),
        .cur_col     (cur_col),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic [7:0] b;
        int nwr;
        int addr;
        int data;
        int col;
        int row;
        int top;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int q_addr[$];
    int q_data[$];
    int q_busy[$];
    int n_busy = 0;

    always @(negedge clk100) begin
        if (!reset) begin
            if (wr_en) begin
                q_addr.push_back(int'(wr_addr));
                q_data.push_back(int'(wr_data));
                q_busy.push_back(int'(busy));
            end
            if (busy) n_busy++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_not_busy(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge clk100);
            k++;
        end
        chk("busy_timeout", int'(busy), 0);
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk100);
        rx_byte = b;
        rbyte_ready = 1'b1;
        repeat (16) @(negedge clk100);
        rbyte_ready = 1'b0;
        repeat (2) @(negedge clk100);
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b);
        repeat (4) @(negedge clk100);
        wait_not_busy(200);
        repeat (4) @(negedge clk100);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n0 = q_addr.size();
        send_byte(v.b);
        chk({tag, "_nwr"}, q_addr.size() - n0, v.nwr);
        if (q_addr.size() > n0 && v.nwr > 0) begin
            chk({tag, "_addr"}, q_addr[q_addr.size()-1], v.addr);
            chk({tag, "_data"}, q_data[q_data.size()-1], v.data);
        end
        chk({tag, "_col"}, int'(cur_col), v.col);
        chk({tag, "_row"}, int'(cur_row), v.row);
        chk({tag, "_top"}, int'(top_row), v.top);
    endtask

    task automatic check_init(input string tag);
        int bad = 0;
        for (int i = 0; i < q_addr.size() && i < ROWS*COLS; i++)
            if (q_addr[i] != i || q_data[i] != 32'h20 || q_busy[i] != 1) bad++;
        chk({tag, "_bad"}, bad, 0);
    endtask

    vec_t ta[13];
    vec_t tb[3];
    vec_t tc[4];

    initial begin
        int n0;
        int b0;
        int lat;
        int bad;

        ta[0]  = '{8'h0D, 0, 0, 0,     0, 0, 0};
        ta[1]  = '{8'h41, 1, 0, 8'h41, 1, 0, 0};
        ta[2]  = '{8'h42, 1, 1, 8'h42, 2, 0, 0};
        ta[3]  = '{8'h08, 1, 1, 8'h20, 1, 0, 0};
        ta[4]  = '{8'h43, 1, 1, 8'h43, 2, 0, 0};
        ta[5]  = '{8'h0D, 0, 0, 0,     0, 0, 0};
        ta[6]  = '{8'h08, 0, 0, 0,     0, 0, 0};
        ta[7]  = '{8'h07, 0, 0, 0,     0, 0, 0};
        ta[8]  = '{8'h7F, 0, 0, 0,     0, 0, 0};
        ta[9]  = '{8'h1F, 0, 0, 0,     0, 0, 0};
        ta[10] = '{8'h7E, 1, 0, 8'h7E, 1, 0, 0};
        ta[11] = '{8'h20, 1, 1, 8'h20, 2, 0, 0};
        ta[12] = '{8'h0D, 0, 0, 0,     0, 0, 0};
        tb[0]  = '{8'h0D, 0, 0,  0,     0, 1, 0};
        tb[1]  = '{8'h79, 1, 80, 8'h79, 1, 1, 0};
        tb[2]  = '{8'h0D, 0, 0,  0,     0, 1, 0};
        tc[0]  = '{8'h5A, 1,  0,   8'h5A, 1, 29, 1};
        tc[1]  = '{8'h0D, 0,  0,   0,     0, 29, 1};
        tc[2]  = '{8'h0A, 80, 159, 8'h20, 0, 29, 2};
        tc[3]  = '{8'h51, 1,  80,  8'h51, 1, 29, 2};

        // Reset state
        repeat (3) @(negedge clk100);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_cur", int'(cur_col) + int'(cur_row), 0);
        chk("rst_top", int'(top_row), 0);
        chk("rst_ovf", int'(overflow), 0);

        // Power-up clear
        reset = 1'b0;
        @(negedge clk100);
        chk("init_busy_hi", int'(busy), 1);
        wait_not_busy(3000);
        repeat (4) @(negedge clk100);
        chk("init_nwr", q_addr.size(), ROWS*COLS);
        chk("init_busy_cycles", n_busy, ROWS*COLS);
        check_init("init");

        // First byte latency: ready raised -> write seen five edges later
        n0 = q_addr.size();
        lat = 0;
        @(negedge clk100);
        rx_byte = 8'h41;
        rbyte_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk100);
            if (wr_en && lat == 0) lat = i;
        end
        rbyte_ready = 1'b0;
        repeat (10) @(negedge clk100);
        chk("A_latency", lat, 5);
        chk("A_nwr", q_addr.size() - n0, 1);
        chk("A_addr", (q_addr.size() > n0) ? q_addr[n0] : -1, 0);
        chk("A_data", (q_data.size() > n0) ? q_data[n0] : -1, 8'h41);
        chk("A_col", int'(cur_col), 1);

        for (int i = 0; i < 13; i++) run_vec(ta[i], $sformatf("ta%0d", i));

        // Full line wraps to the next row
        n0 = q_addr.size();
        for (int i = 0; i < COLS; i++) send_byte(8'h78);
        chk("wrap_nwr", q_addr.size() - n0, COLS);
        chk("wrap_last_addr", q_addr[q_addr.size()-1], 79);
        chk("wrap_col", int'(cur_col), 0);
        chk("wrap_row", int'(cur_row), 1);

        for (int i = 0; i < 3; i++) run_vec(tb[i], $sformatf("tb%0d", i));

        n0 = q_addr.size();
        for (int i = 0; i < 28; i++) send_byte(8'h0A);
        chk("lf_nwr", q_addr.size() - n0, 0);
        chk("lf_row", int'(cur_row), 29);
        chk("lf_top", int'(top_row), 0);

        // First scroll clears physical row 0
        n0 = q_addr.size();
        b0 = n_busy;
        send_byte(8'h0A);
        bad = 0;
        for (int i = n0; i < q_addr.size(); i++)
            if (q_addr[i] != i - n0 || q_data[i] != 32'h20 || q_busy[i] != 1) bad++;
        chk("scroll_nwr", q_addr.size() - n0, COLS);
        chk("scroll_bad", bad, 0);
        chk("scroll_busy_cycles", n_busy - b0, COLS);
        chk("scroll_top", int'(top_row), 1);
        chk("scroll_row", int'(cur_row), 29);

        for (int i = 0; i < 4; i++) run_vec(tc[i], $sformatf("tc%0d", i));

        // Top row wraps ROWS-1 -> 0
        for (int i = 0; i < 28; i++) send_byte(8'h0A);
        chk("topwrap_top", int'(top_row), 0);
        chk("topwrap_last_addr", q_addr[q_addr.size()-1], 2399);
        chk("topwrap_col", int'(cur_col), 1);
        run_vec('{8'h57, 1, 2321, 8'h57, 2, 29, 0}, "W");

        // Reset mid-INIT, then two back-to-back bytes during INIT
        reset = 1'b1;
        repeat (2) @(negedge clk100);
        reset = 1'b0;
        repeat (100) @(negedge clk100);
        reset = 1'b1;
        @(negedge clk100);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cur", int'(cur_col) + int'(cur_row) + int'(top_row), 0);
        q_addr.delete();
        q_data.delete();
        q_busy.delete();
        @(negedge clk100);
        reset = 1'b0;
        pulse(8'h4D);
        pulse(8'h4E);
        chk("ovf_set", int'(overflow), 1);
        wait_not_busy(3000);
        repeat (10) @(negedge clk100);
        chk("reinit_nwr", q_addr.size(), ROWS*COLS + 1);
        check_init("reinit");
        chk("pend_addr", (q_addr.size() > ROWS*COLS) ? q_addr[ROWS*COLS] : -1, 0);
        chk("pend_data", (q_data.size() > ROWS*COLS) ? q_data[ROWS*COLS] : -1, 8'h4D);
        chk("pend_col", int'(cur_col), 1);
        run_vec('{8'h4F, 1, 1, 8'h4F, 2, 0, 0}, "O");
        chk("ovf_sticky", int'(overflow), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
